pc_sequencer: RTL and testbench

//  Fetch/execute sequencer for the mini processor. Owns the program counter and steps it

---
 rtl/pc_seq_pkg.sv | 25 ++
 rtl/pc_ret_stack.sv | 50 +++++
 rtl/pc_sequencer.sv | 137 +++++++++++++
 tb/tb_pc_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// ---------------------------------------------------------------------------
// pc_seq_pkg : opcode constants and state encoding for the pc sequencer
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pc_seq_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_JMP  = 4'h1;
  localparam logic [3:0] OP_BZ   = 4'h2;
  localparam logic [3:0] OP_CALL = 4'h3;
  localparam logic [3:0] OP_RET  = 4'h4;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/pc_ret_stack.sv
// ---------------------------------------------------------------------------
// pc_ret_stack : LIFO of return addresses; dout shows the current top entry
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pc_ret_stack #(
  parameter int W = 4,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int CW = $clog2(D + 1);
  localparam int AW = (D > 1) ? $clog2(D) : 1;

  logic [W-1:0]  mem [D];
  logic [CW-1:0] count;

  assign full  = (count == CW'(D));
  assign empty = (count == '0);
  assign dout  = mem[AW'(count - CW'(1))];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CW'(1);
    end else if (pop && !empty) begin
      count <= count - CW'(1);
    end
  end

  // Storage needs no reset: entries are only read while count covers them.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[AW'(count)] <= din;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer : fetch/execute sequencer owning the program counter.
//                Define PC_SEQ_CALL_STACK_EN to add CALL/RET with a return stack.
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int          PC_W     = 4,
  parameter int unsigned RESET_PC = 0,
  parameter int          STACK_D  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            fetch_req,
  input  logic            fetch_ack,
  input  logic [7:0]      instr_i,
  input  logic            zero_i,
  output logic [PC_W-1:0] pc,
  output logic [7:0]      ir,
  output logic            exec_en,
  output logic            halted,
  output logic            stack_err
);

  state_t          state;
  logic [3:0]      op;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_next;

  assign op     = ir[7:4];
  assign target = PC_W'(ir[3:0]);
  assign pc_inc = pc + PC_W'(1);

`ifdef PC_SEQ_CALL_STACK_EN
  logic            do_call;
  logic            do_ret;
  logic            stk_full;
  logic            stk_empty;
  logic [PC_W-1:0] stk_top;

  assign do_call = (state == ST_EXEC) && (op == OP_CALL);
  assign do_ret  = (state == ST_EXEC) && (op == OP_RET);

  pc_ret_stack #(
    .W (PC_W),
    .D (STACK_D)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (do_call),
    .pop   (do_ret),
    .din   (pc_inc),
    .dout  (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stack_err <= 1'b0;
    end else if ((do_call && stk_full) || (do_ret && stk_empty)) begin
      stack_err <= 1'b1;
    end
  end
`else
  assign stack_err = 1'b0;
`endif

  always_comb begin
    pc_next = pc_inc;
    case (op)
      OP_JMP:  pc_next = target;
      OP_BZ:   pc_next = zero_i ? target : pc_inc;
      OP_HALT: pc_next = pc;
`ifdef PC_SEQ_CALL_STACK_EN
      OP_CALL: pc_next = target;
      OP_RET:  pc_next = stk_empty ? pc_inc : stk_top;
`endif
      default: pc_next = pc_inc;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      pc        <= PC_W'(RESET_PC);
      ir        <= '0;
      fetch_req <= 1'b0;
      exec_en   <= 1'b0;
      halted    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_FETCH;
            fetch_req <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (fetch_ack) begin
            ir        <= instr_i;
            state     <= ST_EXEC;
            fetch_req <= 1'b0;
            exec_en   <= 1'b1;
          end
        end
        ST_EXEC: begin
          exec_en <= 1'b0;
          pc      <= pc_next;
          if (op == OP_HALT) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else begin
            state     <= ST_FETCH;
            fetch_req <= 1'b1;
          end
        end
        ST_HALT: begin
          if (start) begin
            state     <= ST_FETCH;
            halted    <= 1'b0;
            fetch_req <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer : directed self-checking bench for pc_sequencer
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       fetch_req;
  logic       fetch_ack;
  logic [7:0] instr_i;
  logic       zero_i;
  logic [3:0] pc;
  logic [7:0] ir;
  logic       exec_en;
  logic       halted;
  logic       stack_err;

  int tests = 0;
  int fails = 0;

  pc_sequencer #(
    .PC_W     (4),
    .RESET_PC (0),
    .STACK_D  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .fetch_req (fetch_req),
    .fetch_ack (fetch_ack),
    .instr_i   (instr_i),
    .zero_i    (zero_i),
    .pc        (pc),
    .ir        (ir),
    .exec_en   (exec_en),
    .halted    (halted),
    .stack_err (stack_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    start     = 1'b0;
    fetch_ack = 1'b0;
    instr_i   = 8'h00;
    zero_i    = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  // Leave IDLE: one start pulse, FETCH follows.
  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("kick_fetch_req", 32'(fetch_req), 32'd1);
  endtask

  // Runs one instruction from a FETCH cycle: wait cycles, ack, EXEC, then checks new pc.
  task automatic run_instr(input string tag, input logic [7:0] ins, input int dly,
                           input logic z, input logic [3:0] exp_pc);
    logic [3:0] pc0;
    pc0 = pc;
    for (int i = 0; i < dly; i++) begin
      fetch_ack = 1'b0;
      step();
      if (i == dly - 1) begin
        chk({tag, "_wait_req"}, 32'(fetch_req), 32'd1);
        chk({tag, "_wait_pc"}, 32'(pc), 32'(pc0));
        chk({tag, "_wait_exec"}, 32'(exec_en), 32'd0);
      end
    end
    fetch_ack = 1'b1;
    instr_i   = ins;
    zero_i    = z;
    step();
    fetch_ack = 1'b0;
    instr_i   = 8'h00;
    chk({tag, "_exec_en"}, 32'(exec_en), 32'd1);
    chk({tag, "_ir"}, 32'(ir), 32'(ins));
    step();
    chk({tag, "_pc"}, 32'(pc), 32'(exp_pc));
    chk({tag, "_exec_off"}, 32'(exec_en), 32'd0);
  endtask

  initial begin
    do_reset();
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_ir", 32'(ir), 32'd0);
    chk("rst_fetch_req", 32'(fetch_req), 32'd0);
    chk("rst_exec_en", 32'(exec_en), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_stack_err", 32'(stack_err), 32'd0);
    step();
    chk("idle_no_req", 32'(fetch_req), 32'd0);

    // NOP sweep: pc walks 1..15 then wraps to 0.
    kick();
    for (int k = 1; k <= 16; k++) begin
      run_instr("nop", 8'h00, 0, 1'b0, 4'(k));
      chk("nop_refetch", 32'(fetch_req), 32'd1);
    end

    // Delayed ack of three cycles.
    run_instr("slow", 8'h00, 3, 1'b0, 4'd1);

    // Control flow.
    run_instr("jmp5", 8'h15, 0, 1'b0, 4'd5);
    run_instr("jmpC", 8'h1C, 1, 1'b0, 4'd12);
    run_instr("bz_t", 8'h23, 0, 1'b1, 4'd3);
    run_instr("bz_nt", 8'h29, 0, 1'b0, 4'd4);
    run_instr("undef", 8'h5A, 0, 1'b1, 4'd5);

    // HALT at pc 7, then resume.
    run_instr("jmp7", 8'h17, 0, 1'b0, 4'd7);
    run_instr("halt", 8'hF0, 0, 1'b0, 4'd7);
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_no_req", 32'(fetch_req), 32'd0);
    fetch_ack = 1'b1;
    step();
    step();
    fetch_ack = 1'b0;
    chk("halt_stay", 32'(halted), 32'd1);
    chk("halt_stay_pc", 32'(pc), 32'd7);
    chk("halt_stay_req", 32'(fetch_req), 32'd0);
    kick();
    chk("resume_halted", 32'(halted), 32'd0);
    chk("resume_pc", 32'(pc), 32'd7);
    run_instr("resume", 8'h00, 0, 1'b0, 4'd8);

    // Async reset in the middle of a FETCH wait.
    step();
    chk("pre_rst_req", 32'(fetch_req), 32'd1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("async_pc", 32'(pc), 32'd0);
    chk("async_req", 32'(fetch_req), 32'd0);
    chk("async_halted", 32'(halted), 32'd0);
    step();
    rst = 1'b1;
    fetch_ack = 1'b1;
    step();
    step();
    fetch_ack = 1'b0;
    chk("post_rst_idle", 32'(fetch_req), 32'd0);
    chk("post_rst_pc", 32'(pc), 32'd0);

`ifdef PC_SEQ_CALL_STACK_EN
    kick();
    run_instr("s_jmp2", 8'h12, 0, 1'b0, 4'd2);
    run_instr("call8", 8'h38, 0, 1'b0, 4'd8);
    run_instr("ret", 8'h40, 0, 1'b0, 4'd3);
    chk("ret_err", 32'(stack_err), 32'd0);
    run_instr("c1", 8'h31, 0, 1'b0, 4'd1);
    run_instr("c2", 8'h32, 0, 1'b0, 4'd2);
    run_instr("c3", 8'h33, 0, 1'b0, 4'd3);
    run_instr("c4", 8'h34, 0, 1'b0, 4'd4);
    chk("full_no_err", 32'(stack_err), 32'd0);
    run_instr("c5", 8'h35, 0, 1'b0, 4'd5);
    chk("overflow_err", 32'(stack_err), 32'd1);
    run_instr("r1", 8'h40, 0, 1'b0, 4'd4);
    run_instr("r2", 8'h40, 0, 1'b0, 4'd3);
    run_instr("r3", 8'h40, 0, 1'b0, 4'd2);
    run_instr("r4", 8'h40, 0, 1'b0, 4'd4);
    do_reset();
    chk("err_cleared", 32'(stack_err), 32'd0);
    kick();
    run_instr("ret_empty", 8'h40, 0, 1'b0, 4'd1);
    chk("underflow_err", 32'(stack_err), 32'd1);
    run_instr("sticky", 8'h00, 0, 1'b0, 4'd2);
    chk("err_sticky", 32'(stack_err), 32'd1);
`else
    kick();
    run_instr("n_jmp2", 8'h12, 0, 1'b0, 4'd2);
    run_instr("call_nop", 8'h38, 0, 1'b0, 4'd3);
    run_instr("ret_nop", 8'h40, 0, 1'b0, 4'd4);
    chk("no_stack_err", 32'(stack_err), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
